// File: rtl/bus_sched_pkg.sv
// Shared types, widths and header decode for the bus round-robin scheduler.
package bus_sched_pkg;

    typedef enum logic [1:0] {IDLE, POP, PUSH} sched_state_e;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned GRANT_W   = 4;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PKT_W_MAX = 256;

    // Destination ID sits in the top byte of the packet header.
    function automatic logic [ID_W-1:0] dest_id(input logic [PKT_W_MAX-1:0] pkt,
                                                input int unsigned          pkt_w);
        return pkt[pkt_w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_rr_picker.sv
// Combinational round-robin search over pending sources, starting after last_grant.
module rr_picker
    import bus_sched_pkg::*;
#(
    parameter int unsigned drvrs = 4
) (
    input  logic [drvrs-1:0]   pndng,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               valid,
    output logic [GRANT_W-1:0] idx
);

    localparam int unsigned IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    int unsigned cand;

    // First pending bit at offsets 1..drvrs from last_grant, wrapping modulo drvrs.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned off = 1; off <= drvrs; off++) begin
            cand = (32'(last_grant) + off) % drvrs;
            if (!valid && pndng[IDX_W'(cand)]) begin
                valid = 1'b1;
                idx   = GRANT_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin packet scheduler: pops one packet from the granted source FIFO and
// pushes it to its destination (or all others on broadcast). Optional BUS_SCHED_STATS_EN adds counters.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [drvrs*pckg_sz-1:0] D_push,
    output logic                     busy,
    output logic [GRANT_W-1:0]       grant_id,
    output logic                     drop
`ifdef BUS_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]         routed_cnt,
    output logic [CNT_W-1:0]         drop_cnt
`endif
);

    sched_state_e         state_q, state_d;
    logic [GRANT_W-1:0]   grant_d;
    logic [GRANT_W-1:0]   last_q, last_d;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;
    logic [drvrs-1:0]     pop_d, push_d;
    logic                 drop_d, busy_d;

    logic [pckg_sz-1:0]   lane_pkt;
    logic [ID_W-1:0]      id;
    logic                 is_bc, is_self, is_uni;
    logic                 pick_valid;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 inc_routed, inc_drop;

    rr_picker #(
        .drvrs (drvrs)
    ) u_picker (
        .pndng      (pndng),
        .last_grant (last_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign D_push = {drvrs{pkt_q}};

    // Next-state and next-output logic; the packet is decoded as it is latched so
    // push/drop become visible in the PUSH cycle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_id;
        last_d     = last_q;
        pkt_d      = pkt_q;
        pop_d      = '0;
        push_d     = '0;
        drop_d     = 1'b0;
        inc_routed = 1'b0;
        inc_drop   = 1'b0;

        lane_pkt = D_pop[32'(grant_id)*pckg_sz +: pckg_sz];
        id       = dest_id(PKT_W_MAX'(lane_pkt), pckg_sz);
        is_bc    = (id == broadcast);
        is_self  = !is_bc && (32'(id) == 32'(grant_id));
        is_uni   = !is_bc && !is_self && (32'(id) < drvrs);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    for (int unsigned i = 0; i < drvrs; i++) begin
                        pop_d[i] = (i == 32'(pick_idx));
                    end
                    state_d = POP;
                end
            end
            POP: begin
                pkt_d = lane_pkt;
                for (int unsigned i = 0; i < drvrs; i++) begin
                    if (is_bc) begin
                        push_d[i] = (i != 32'(grant_id));
                    end else if (is_uni) begin
                        push_d[i] = (i == 32'(id));
                    end
                end
                drop_d     = !is_bc && !is_self && !is_uni;
                inc_routed = is_bc || is_uni;
                inc_drop   = !(is_bc || is_uni);
                state_d    = PUSH;
            end
            PUSH: begin
                last_d  = grant_id;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_id <= '0;
            last_q   <= GRANT_W'(drvrs - 1);
            pkt_q    <= '0;
            pop      <= '0;
            push     <= '0;
            drop     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_id <= grant_d;
            last_q   <= last_d;
            pkt_q    <= pkt_d;
            pop      <= pop_d;
            push     <= push_d;
            drop     <= drop_d;
            busy     <= busy_d;
        end
    end

`ifdef BUS_SCHED_STATS_EN
    // Saturating packet counters; self-addressed packets count as dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            routed_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (inc_routed && (routed_cnt != '1)) begin
                routed_cnt <= routed_cnt + 1'b1;
            end
            if (inc_drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
`else
    logic stats_unused;
    assign stats_unused = inc_routed ^ inc_drop;
`endif

endmodule
